// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multi-word add controller and its prefix adder:
//   - state_t            : controller FSM states (IDLE / RUN / DONE)
//   - DEF_WIDTH          : default chunk width in bits
//   - DEF_LEVELS         : default prefix-tree depth
//   - DEF_NWORDS         : default number of chunks per operand
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LEVELS = 2;
  localparam int DEF_NWORDS = 4;

endpackage : adder_pkg

// File: rtl/prefix_adder.sv
// ---------------------------------------------------------------------------
// prefix_adder
// Combinational WIDTH-bit adder with carry-in, built as a Kogge-Stone style
// parallel-prefix tree of LEVELS levels. LEVELS must satisfy
// 2**LEVELS >= WIDTH so that the group generate/propagate terms span every
// bit position.
//
// Ports:
//   a, b  : input  [WIDTH-1:0]  addends
//   cin   : input               carry into bit 0
//   sum   : output [WIDTH-1:0]  a + b + cin (low WIDTH bits)
//   cout  : output              carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEVELS = DEF_LEVELS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Working generate/propagate vectors. After the loop, g[i]/p[i] are the
  // group terms for bits [i:0].
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_nx;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    g_nx = '0;
    p_nx = '0;
    c    = '0;
    for (int l = 0; l < LEVELS; l++) begin
      g_nx = g;
      p_nx = p;
      // Positions below the span distance keep their terms unchanged.
      for (int i = (1 << l); i < WIDTH; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_nx[i] = p[i] & p[i - (1 << l)];
      end
      g = g_nx;
      p = p_nx;
    end
    // Carry into bit i+1 is the group generate of [i:0], or the carry-in
    // propagated through the whole group.
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i + 1] = g[i] | (p[i] & cin);
    end
    sum  = (a ^ b) ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule : prefix_adder

// File: rtl/multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// multiword_add_ctrl
// Adds two NWORDS*WIDTH-bit operands one WIDTH-bit chunk per cycle through a
// single shared prefix adder, least significant chunk first, with a ripple
// carry register between chunks. Operands are latched at acceptance, so the
// inputs may change freely while the operation runs.
//
// Timing: a request accepted on edge 0 walks chunks 0..NWORDS-1 on edges
// 1..NWORDS and the result is presented from the following cycle, i.e. in
// cycle NWORDS+1 counting the accepting cycle as cycle 0.
//
// Optional feature (macro MWADD_SUB_EN): adds a 'sub' input latched with the
// operands; when set, the block computes x - y - carry_in as
// x + ~y + ~carry_in, so carry_out = 1 means "no borrow".
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   x, y, carry_in      : operands and initial carry
//   sub                 : subtract select (MWADD_SUB_EN builds only)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   z, carry_out        : sum and final carry
//   busy                : high in RUN or DONE
// ---------------------------------------------------------------------------
module multiword_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEVELS = DEF_LEVELS,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NWORDS*WIDTH-1:0] x,
  input  logic [NWORDS*WIDTH-1:0] y,
  input  logic                    carry_in,
`ifdef MWADD_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NWORDS*WIDTH-1:0] z,
  output logic                    carry_out,
  output logic                    busy
);

  localparam int TW   = NWORDS * WIDTH;
  localparam int IDXW = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic              carry_q, carry_d;
  logic [TW-1:0]     x_q,     x_d;
  logic [TW-1:0]     y_q,     y_d;
  logic [TW-1:0]     z_q,     z_d;
`ifdef MWADD_SUB_EN
  logic              sub_q,   sub_d;
`endif

  // Chunk views of the latched operands and the chunk-wise next value of z.
  logic [WIDTH-1:0]  x_chunk [NWORDS];
  logic [WIDTH-1:0]  y_chunk [NWORDS];
  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;
  logic              run_step;

  assign run_step = (state_q == RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_chunk
      assign x_chunk[gi] = x_q[gi*WIDTH +: WIDTH];
      assign y_chunk[gi] = y_q[gi*WIDTH +: WIDTH];
      // Only the chunk under the index is rewritten during RUN.
      assign z_d[gi*WIDTH +: WIDTH] =
        (run_step && (idx_q == IDXW'(gi))) ? add_sum : z_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign add_a = x_chunk[idx_q];
`ifdef MWADD_SUB_EN
  assign add_b = sub_q ? ~y_chunk[idx_q] : y_chunk[idx_q];
`else
  assign add_b = y_chunk[idx_q];
`endif

  prefix_adder #(
    .WIDTH  (WIDTH),
    .LEVELS (LEVELS)
  ) u_prefix_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
`ifdef MWADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
`ifdef MWADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef MWADD_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          idx_d   = '0;
`ifdef MWADD_SUB_EN
          sub_d   = sub;
          // Subtraction feeds the inverted carry-in as the initial carry.
          carry_d = sub ? ~carry_in : carry_in;
`else
          carry_d = carry_in;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Index parks on the last chunk; it is cleared on the next accept.
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign z         = z_q;
  assign carry_out = carry_q;

endmodule : multiword_add_ctrl

// File: tb/tb_multiword_add_ctrl.sv
module tb_multiword_add_ctrl;

  localparam int W  = 4;
  localparam int L  = 2;
  localparam int N  = 4;
  localparam int TW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] x;
  logic [TW-1:0] y;
  logic          carry_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] z;
  logic          carry_out;
  logic          busy;
`ifdef MWADD_SUB_EN
  logic          sub;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(
    .WIDTH  (W),
    .LEVELS (L),
    .NWORDS (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .carry_in  (carry_in),
`ifdef MWADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .carry_out (carry_out),
    .busy      (busy)
  );

  typedef struct {
    logic [TW-1:0] xv;
    logic [TW-1:0] yv;
    logic          cin;
    logic [TW-1:0] exp_z;
    logic          exp_c;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Wait (at negedges) for out_valid; lat is the cycle number counting the
  // accepting cycle as 0, or -1 on timeout. Entered at the negedge of cycle 1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL timeout: out_valid not seen within 20 cycles");
    end
  endtask

  // One full request/response. Inputs are scrambled right after acceptance.
  task automatic run_req(input logic [TW-1:0] xv, input logic [TW-1:0] yv,
                         input logic cin, input logic sb,
                         output logic [TW-1:0] zv, output logic cv, output int lat);
    @(negedge clk);
    x        = xv;
    y        = yv;
    carry_in = cin;
`ifdef MWADD_SUB_EN
    sub      = sb;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x        = ~xv;
    y        = xv ^ yv ^ 16'h5A5A;
    carry_in = ~cin;
`ifdef MWADD_SUB_EN
    sub      = ~sb;
`endif
    wait_done(lat);
    zv = z;
    cv = carry_out;
    if (lat >= 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    $display("req x=%h y=%h cin=%b sub=%b -> z=%h cout=%b lat=%0d", xv, yv, cin, sb, zv, cv, lat);
  endtask

  logic [TW-1:0] zr;
  logic          cr;
  int            lat;
  logic [TW:0]   ref_sum;
  logic [TW-1:0] rx;
  logic [TW-1:0] ry;
  logic          rc;
  logic          rs;
  int            ov_seen;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    carry_in  = 1'b0;
`ifdef MWADD_SUB_EN
    sub       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_z",         32'(z),         32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);

    // Reset wins over a simultaneous request.
    in_valid = 1'b1;
    x        = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_req(vecs[i].xv, vecs[i].yv, vecs[i].cin, 1'b0, zr, cr, lat);
      check($sformatf("vec%0d_z", i),    32'(zr),  32'(vecs[i].exp_z));
      check($sformatf("vec%0d_cout", i), 32'(cr),  32'(vecs[i].exp_c));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'(N + 1));
      check($sformatf("vec%0d_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: hold out_ready low 3 cycles, poke in_valid meanwhile.
    @(negedge clk);
    x        = 16'h1234;
    y        = 16'h4321;
    carry_in = 1'b0;
`ifdef MWADD_SUB_EN
    sub      = 1'b0;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_z", c),         32'(z),         32'h5555);
      check($sformatf("bp%0d_cout", c),      32'(carry_out), 32'd0);
      check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      x        = 16'hFFFF;
      y        = 16'hFFFF;
      carry_in = 1'b1;
      @(negedge clk);
    end
    check("bp_z_after_ignored", 32'(z), 32'h5555);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    $display("backpressure sequence z=%h", z);

    // Reset abort in the second RUN cycle.
    @(negedge clk);
    x        = 16'h1234;
    y        = 16'h4321;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);            // first RUN cycle
    in_valid = 1'b0;
    @(negedge clk);            // second RUN cycle
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_z",         32'(z),         32'd0);
    check("abort_carry_out", 32'(carry_out), 32'd0);
    ov_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov_seen++;
    end
    check("abort_no_out_valid", 32'(ov_seen), 32'd0);
    $display("reset abort sequence out_valid_pulses=%0d", ov_seen);
    run_req(16'h1234, 16'h4321, 1'b0, 1'b0, zr, cr, lat);
    check("reissue_z",   32'(zr),  32'h5555);
    check("reissue_lat", 32'(lat), 32'(N + 1));

`ifdef MWADD_SUB_EN
    run_req(16'h0005, 16'h0003, 1'b0, 1'b1, zr, cr, lat);
    check("sub1_z",    32'(zr), 32'h0002);
    check("sub1_cout", 32'(cr), 32'd1);
    run_req(16'h0003, 16'h0005, 1'b0, 1'b1, zr, cr, lat);
    check("sub2_z",    32'(zr), 32'hFFFE);
    check("sub2_cout", 32'(cr), 32'd0);
`endif

    // Random regression against an arithmetic reference.
    for (int r = 0; r < 1000; r++) begin
      rx = TW'($urandom);
      ry = TW'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef MWADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (rs) ref_sum = {1'b0, rx} + {1'b0, ~ry} + {16'd0, ~rc};
      else    ref_sum = {1'b0, rx} + {1'b0, ry}  + {16'd0, rc};
      run_req(rx, ry, rc, rs, zr, cr, lat);
      check($sformatf("rnd%0d_z", r),    32'(zr), 32'(ref_sum[TW-1:0]));
      check($sformatf("rnd%0d_cout", r), 32'(cr), 32'(ref_sum[TW]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiword_add_ctrl

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: chunk width in bits, passed to the shared prefix adder.
REQ-002 Parameter LEVELS, default 2: prefix-tree depth, passed to the shared prefix adder.
REQ-003 Parameter NWORDS, default 4, minimum 2: number of chunks per operand.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 x  input  NWORDS*WIDTH  operand A.
REQ-009 y  input  NWORDS*WIDTH  operand B.
REQ-010 carry_in  input  1  initial carry.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 z  output  NWORDS*WIDTH  sum.
REQ-014 carry_out  output  1  final carry.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1. On in_valid, the block SHALL latch x, y and carry_in, clear the chunk index, and go to RUN.
REQ-018 RUN: each cycle the block SHALL add chunk[idx] of the latched x and y plus the carry register through the single prefix adder instance.
REQ-019 In each RUN cycle, z chunk[idx] SHALL take the adder sum, the carry register SHALL take the adder carry_out, and idx SHALL increment.
REQ-020 When idx==NWORDS-1, the block SHALL go to DONE after that cycle's update; idx SHALL never exceed NWORDS-1.
REQ-021 DONE: out_valid=1, with z and carry_out stable. On out_ready, the block SHALL go to IDLE.
REQ-022 out_valid SHALL rise exactly NWORDS+1 cycles after the accepting edge.
REQ-023 in_ready SHALL be 0 in RUN and DONE. The next request is accepted no earlier than the cycle after the DONE handshake.
REQ-024 in_valid while not in IDLE SHALL be ignored, and latched operands SHALL be unaffected.
REQ-025 Changes to x, y or carry_in after acceptance SHALL NOT affect the result.
REQ-026 carry_out SHALL equal the carry register at DONE: the carry of the full NWORDS*WIDTH-bit addition.
REQ-027 Width rule: z = (x + y + carry_in) mod 2^(NWORDS*WIDTH); carry_out is bit NWORDS*WIDTH of that sum.

Reset
REQ-028 rst SHALL force IDLE, idx=0 and carry register=0, and SHALL clear z, carry_out, out_valid and busy to 0.
REQ-029 rst asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-031 Macro MWADD_SUB_EN SHALL control the subtract feature.
REQ-032 With MWADD_SUB_EN defined, the block SHALL add input port sub (1 bit), latched at acceptance.
REQ-033 With sub=1, the block SHALL compute x - y - carry_in as x + ~y + ~carry_in, per chunk.
REQ-034 With sub=1, carry_out SHALL be 1 when there is no borrow.
REQ-035 Without MWADD_SUB_EN, the sub port and its logic SHALL be absent and the behaviour SHALL be add-only.

Structure
REQ-036 Shared package adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/LEVELS/NWORDS constants.
REQ-037 The block SHALL instantiate exactly one prefix_adder sub-module, with WIDTH and LEVELS passed through.
REQ-038 idx SHALL be sized $clog2(NWORDS).

Verification (WIDTH=4, LEVELS=2, NWORDS=4)
REQ-039 x=0x0003, y=0x0005, cin=0, accepted at cycle 0 -> out_valid at cycle 5, z=0x0008, carry_out=0.
REQ-040 x=0xFFFF, y=0x0001, cin=0 -> carry ripples through all chunks: z=0x0000, carry_out=1; then x=0x0000, y=0x0000, cin=1 -> z=0x0001, carry_out=0.
REQ-041 Backpressure with out_ready held 0 for 3 cycles in DONE -> z and carry_out hold, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-042 rst pulsed at the second RUN cycle of x=0x1234, y=0x4321 -> no out_valid, all outputs 0, in_ready=1 the cycle after; re-issue -> z=0x5555.
REQ-043 MWADD_SUB_EN defined: 0x0005-0x0003, cin=0 -> z=0x0002, carry_out=1; 0x0003-0x0005 -> z=0xFFFE, carry_out=0.
REQ-044 Random regression of 1000 requests against a reference model: each result matches with (x + y + carry_in) per REQ-027.
